// File: rtl/hit_window_counter.sv
// Counts z=1 hits over a window of N_SAMPLES upstream handshakes, then hands
// the count downstream on a second dav_/rfd handshake while upstream is stalled.
module hit_window_counter #(
    parameter int N_SAMPLES = 256,
    parameter int W         = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         dav_,
    input  logic         z,
    output logic         rfd,
    output logic         dav_out_,
    input  logic         rfd_out,
    output logic [W-1:0] hits
);

    localparam logic [1:0] S_IN  = 2'd0;
    localparam logic [1:0] S_ACK = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;
    localparam logic [1:0] S_REL = 2'd3;

    localparam logic [W-1:0] N_LAST = W'(N_SAMPLES);
    localparam logic [W-1:0] ONE    = W'(1);

    logic [1:0]   star;
    logic [W-1:0] cnt;
    logic [W-1:0] hit;
    logic [W-1:0] hits_r;

    assign hits = hits_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            star     <= S_IN;
            rfd      <= 1'b0;
            dav_out_ <= 1'b1;
            cnt      <= '0;
            hit      <= '0;
            hits_r   <= '0;
        end else begin
            case (star)
                S_IN: begin
                    if (!dav_) begin
                        hit  <= hit + {{(W-1){1'b0}}, z};
                        cnt  <= cnt + ONE;
                        rfd  <= 1'b1;
                        star <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (dav_) begin
                        rfd <= 1'b0;
                        // The final sample's release and the result offer share one edge.
                        if (cnt == N_LAST) begin
                            hits_r   <= hit;
                            dav_out_ <= 1'b0;
                            star     <= S_OUT;
                        end else begin
                            star <= S_IN;
                        end
                    end
                end
                S_OUT: begin
                    if (rfd_out) begin
                        dav_out_ <= 1'b1;
                        star     <= S_REL;
                    end
                end
                S_REL: begin
                    // Window counters clear only once downstream has fully released.
                    if (!rfd_out) begin
                        cnt  <= '0;
                        hit  <= '0;
                        star <= S_IN;
                    end
                end
                default: begin
                    star <= S_IN;
                end
            endcase
        end
    end

endmodule

// File: doc/hit_window_counter.md
# hit_window_counter

Downstream consumer of the circle-membership stage. It accepts one z bit per dav_/rfd handshake and counts how many of a fixed window of N_SAMPLES points fell inside the area. At the end of each window it presents the hit count on a second dav_/rfd handshake, towards the display or host stage. Upstream is stalled while the result is being handed off, so no sample is lost or double-counted.

## Interface
- N_SAMPLES, 256: samples per window, ≥1.
- W, 9: counter/result width; must satisfy 2^W > N_SAMPLES.

- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- dav_  in  1  upstream data-valid, active low.
- z  in  1  upstream sample: 1 = point inside area; valid while dav_=0.
- rfd  out  1  acknowledge to upstream.
- dav_out_  out  1  result valid to downstream, active low.
- rfd_out  in  1  downstream acknowledge.
- hits  out  W  hit count of last completed window; stable while dav_out_=0.

## Operation
- Internal registers:
  - CNT (W bits): samples taken this window.
  - HIT (W bits): hits this window.
  - HITS_R (W bits): drives hits.
  - STAR (2 bits): state.
- S_IN (rfd=0, dav_out_=1):
  - If dav_=0: HIT<=HIT+z, CNT<=CNT+1, rfd<=1, go to S_ACK.
  - Otherwise hold.
- S_ACK (rfd=1): wait for dav_=1, then rfd<=0.
  - If CNT==N_SAMPLES: HITS_R<=HIT, dav_out_<=0, go to S_OUT.
  - Otherwise go to S_IN.
- S_OUT (dav_out_=0, rfd=0): wait for rfd_out=1, then dav_out_<=1, go to S_REL.
- S_REL (dav_out_=1, rfd=0): wait for rfd_out=0, then CNT<=0, HIT<=0, go to S_IN.
- Upstream protocol matches the producer: producer lowers dav_, consumer raises rfd, producer raises dav_, consumer lowers rfd.
- Downstream protocol is the same with roles swapped: this block is the producer.
- z is sampled only on the S_IN cycle where dav_=0. z changes at any other time are ignored.
- Arithmetic is natural unsigned. HIT ≤ CNT ≤ N_SAMPLES < 2^W, so there is no overflow and no wrap.
- HITS_R changes only on the S_ACK→S_OUT transition and holds through S_OUT, S_REL and the whole next window.

## Timing
- Reset values: rfd=0, dav_out_=1, hits=0; CNT=HIT=0; STAR=S_IN.
- Reset has priority over every state action. A reset mid-window or mid-handoff discards the partial window and drops rfd/dav_out_ to their idle values on the next edge.
- dav_ low during reset is not consumed. It is accepted on the first edge after reset deasserts, if still low.
- Acceptance latency: rfd rises 1 clock after the edge on which dav_=0 is sampled in S_IN.
- Release latency: rfd falls 1 clock after dav_=1 is sampled in S_ACK.
- Result latency: dav_out_ falls on the same edge that releases rfd for the N_SAMPLES-th sample.
- Handoff: dav_out_ rises 1 clock after rfd_out=1 is sampled. The next sample can be accepted no earlier than 1 clock after rfd_out=0 is sampled.
- No combinational input-to-output paths. All outputs are registered.
- N_SAMPLES=1: every sample produces a result, and hits ∈ {0,1}.
- dav_ held low across consecutive edges counts once. A new sample requires dav_ to go high and then low again.
- rfd_out already 1 when entering S_OUT: dav_out_ rises on the next edge. dav_out_ is low for exactly 1 cycle, which is legal.

## Test plan
- Reset: assert reset for 2 clocks with dav_=0 and rfd_out=0. Required: rfd=0, dav_out_=1, hits=0 throughout. One sample is accepted after release.
- Full window, N_SAMPLES=4: feed z=1,0,1,1 with a compliant producer model. Required: dav_out_ goes low with hits=3, and exactly 4 rfd pulses occur.
- Back-pressure: feed N_SAMPLES=4 samples, all z=1, while downstream holds rfd_out=0 for 20 clocks, and keep dav_=0 offered upstream. Required: rfd stays 0, dav_out_ stays 0, hits holds 4. After the handshake completes, the next window starts from 0.
- All-miss plus N_SAMPLES=1: feed z=0. Required: hits=0 result. A second sample with z=1 gives hits=1.
- Held dav_: hold dav_=0 for 10 clocks with z=1. Required: CNT increments once, and rfd stays 1 until dav_ rises.
- Reset mid-window (N_SAMPLES=4): take 2 hits, assert reset, then feed 4 samples with z=0. Required: hits=0, with no residue from the aborted window.
